// File: rtl/flex_counter_pkg.sv
// Shared definitions for the flexible up-counter family: default width and count type.
package flex_counter_pkg;

    localparam int unsigned FC_WIDTH = 16;

    typedef logic [0:FC_WIDTH-1] fc_count_t;

endpackage

// File: rtl/fc_next_val.sv
// Combinational next-count generator: wrapped increment plus terminal-value decode.
module fc_next_val
    import flex_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = FC_WIDTH,
    parameter longint unsigned MAX_VAL = {WIDTH{1'b1}},
    parameter longint unsigned STEP    = 1
) (
    input  logic [0:WIDTH-1] i_count,
    output logic [0:WIDTH-1] o_next,
    output logic             o_at_max
);

    // One extra bit keeps count+STEP from overflowing before the wrap compare.
    localparam logic [WIDTH:0] LP_MAX    = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] LP_STEP   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] LP_THRESH = LP_MAX - LP_STEP;
    localparam logic [WIDTH:0] LP_WRAP   = LP_MAX + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w_ext;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_next;

    assign w_ext    = {1'b0, i_count};
    assign w_sum    = w_ext + LP_STEP;
    assign w_next   = (w_ext > LP_THRESH) ? (w_sum - LP_WRAP) : w_sum;
    assign o_next   = w_next[WIDTH-1:0];
    assign o_at_max = (w_ext == LP_MAX);

endmodule

// File: rtl/flex_up_counter.sv
// Enable-gated up-counter with configurable width, terminal value and step.
// Count is MSB-first ([0:WIDTH-1]); rollover_flag decodes the registered count only.
module flex_up_counter
    import flex_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = FC_WIDTH,
    parameter longint unsigned MAX_VAL = {WIDTH{1'b1}},
    parameter longint unsigned STEP    = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             enable,
    output logic [0:WIDTH-1] count,
    output logic             rollover_flag
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("flex_up_counter: WIDTH must be in 1..64");
    end
    if (STEP < 64'd1 || STEP > MAX_VAL) begin : g_bad_step
        $error("flex_up_counter: STEP must satisfy 1 <= STEP <= MAX_VAL");
    end
    if (WIDTH < 64 && (MAX_VAL >> WIDTH) != 64'd0) begin : g_bad_max
        $error("flex_up_counter: MAX_VAL does not fit in WIDTH bits");
    end

    logic [0:WIDTH-1] r_count;
    logic [0:WIDTH-1] w_next;
    logic             w_at_max;

    fc_next_val #(
        .WIDTH  (WIDTH),
        .MAX_VAL(MAX_VAL),
        .STEP   (STEP)
    ) u_next (
        .i_count (r_count),
        .o_next  (w_next),
        .o_at_max(w_at_max)
    );

    // NOTE: state updates use <= so every register samples pre-edge values;
    // nrst is in the sensitivity list, so it clears the count without a clock.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_next;
        end
    end

    assign count         = r_count;
    assign rollover_flag = w_at_max;

    a_enable_known: assert property (@(posedge clk) disable iff (nrst) !$isunknown(enable));

endmodule

// File: tb/tb_flex_up_counter.sv
// Directed self-checking bench for flex_up_counter: default, MAX_VAL=5 and STEP=4 variants.
module tb_flex_up_counter;
    import flex_counter_pkg::*;

    logic clk = 1'b0;
    logic nrst;
    logic en_a;
    logic en_b;
    logic en_c;

    fc_count_t  cnt_a;
    logic       flag_a;
    logic [0:15] cnt_b;
    logic       flag_b;
    logic [0:3] cnt_c;
    logic       flag_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    flex_up_counter dut (
        .clk          (clk),
        .nrst         (nrst),
        .enable       (en_a),
        .count        (cnt_a),
        .rollover_flag(flag_a)
    );

    flex_up_counter #(.WIDTH(16), .MAX_VAL(64'd5), .STEP(64'd1)) dut_max5 (
        .clk          (clk),
        .nrst         (nrst),
        .enable       (en_b),
        .count        (cnt_b),
        .rollover_flag(flag_b)
    );

    flex_up_counter #(.WIDTH(4), .MAX_VAL(64'd9), .STEP(64'd4)) dut_step4 (
        .clk          (clk),
        .nrst         (nrst),
        .enable       (en_c),
        .count        (cnt_c),
        .rollover_flag(flag_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after a rising edge, so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_a;
        int exp_b [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
        int exp_c [6] = '{4, 8, 2, 6, 0, 4};

        nrst = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        en_c = 1'b0;

        // Reset held for two edges, then released with enable low.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_count", cnt_a, 0);
            check("reset_flag", flag_a, 0);
        end
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_count", cnt_a, 0);
            check("idle_flag", flag_a, 0);
        end

        // 32 enabled cycles, one increment each.
        en_a = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            check("inc_count", cnt_a, i);
        end
        check("inc_final_0020", cnt_a, 16'h0020);

        // 32 disabled cycles: value holds.
        en_a = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check("hold_count", cnt_a, 32);
        end

        // Reset, count to 17, then assert reset between edges.
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        en_a = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check("pre_mid_reset", cnt_a, i);
        end
        #2;
        nrst = 1'b1;
        #1;
        check("async_clear", cnt_a, 0);
        en_a = 1'b0;
        tick();
        check("held_in_reset", cnt_a, 0);
        nrst = 1'b0;
        en_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("resume_count", cnt_a, i);
        end

        // Enable toggling every cycle: advance only on enabled edges.
        exp_a = 3;
        for (int i = 0; i < 8; i++) begin
            en_a = (i % 2 == 1);
            tick();
            if (i % 2 == 1) exp_a++;
            check("toggle_count", cnt_a, exp_a);
        end
        en_a = 1'b0;

        // MAX_VAL=5 variant wraps 5 -> 0; flag only at 5.
        check("max5_start", cnt_b, 0);
        en_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("max5_count", cnt_b, exp_b[i]);
            check("max5_flag", flag_b, (exp_b[i] == 5) ? 1 : 0);
        end
        en_b = 1'b0;

        // STEP=4, MAX_VAL=9 variant exercises the wrap correction.
        en_c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("step4_count", cnt_c, exp_c[i]);
            check("step4_flag", flag_c, 0);
        end
        en_c = 1'b0;

        // Default params: run up to FFFE, then FFFF with flag, then 0000.
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        en_a = 1'b1;
        repeat (16'hFFFE) @(posedge clk);
        #1;
        check("preload_fffe", cnt_a, 16'hFFFE);
        check("preload_flag", flag_a, 0);
        tick();
        check("term_ffff", cnt_a, 16'hFFFF);
        check("term_flag", flag_a, 1);
        tick();
        check("wrap_0000", cnt_a, 16'h0000);
        check("wrap_flag", flag_a, 0);
        en_a = 1'b0;
        tick();
        check("wrap_hold", cnt_a, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
